// File: rtl/word_memory_pkg.sv
// Shared types and constants for the word_memory store and its clear sequencer.
package word_memory_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  function automatic int unsigned bytes_per_word(input int unsigned width);
    return width / BYTE_W;
  endfunction

endpackage

// File: rtl/word_memory_if.sv
// Request/response bundle between a word_memory user (master) and the store (slave).
interface word_memory_if
  import word_memory_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned BE_W   = bytes_per_word(WIDTH);

  logic              store;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  data;
  logic [BE_W-1:0]   be;
  logic              load;
  logic [ADDR_W-1:0] rd_addr;
  logic              clear;
  logic [WIDTH-1:0]  q;
  logic              q_valid;
  logic              busy;

  modport master (
    output store, wr_addr, data, be, load, rd_addr, clear,
    input  q, q_valid, busy
  );

  modport slave (
    input  store, wr_addr, data, be, load, rd_addr, clear,
    output q, q_valid, busy
  );
endinterface

// File: rtl/word_memory_clear_ctrl.sv
// Sequences the zeroing sweep over every word after reset or a clear request.
module mem_clear_ctrl
  import word_memory_pkg::*;
#(
  parameter  int unsigned DEPTH  = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // busy is registered from the next state so it drops on the same edge IDLE is entered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (clear_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == CLEAR);
  end

  assign busy_o     = busy_q;
  assign clr_we_o   = busy_q;
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/word_memory.sv
// DEPTH x WIDTH word store: byte-enabled writes, write-first registered read, self-clearing.
module word_memory
  import word_memory_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  word_memory_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned BE_W   = bytes_per_word(WIDTH);

  if ((WIDTH % BYTE_W) != 0 || DEPTH < 2) begin : g_param_check
    $error("word_memory: WIDTH must be a multiple of 8 and DEPTH must be >= 2");
  end

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  mem_clear_ctrl #(.DEPTH(DEPTH)) u_clear_ctrl (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (bus.clear),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_in_range_c;
  logic             rd_in_range_c;

  // Only non-power-of-two depths can see addresses past the last word
  if ((1 << ADDR_W) == DEPTH) begin : g_pow2
    assign wr_in_range_c = 1'b1;
    assign rd_in_range_c = 1'b1;
  end else begin : g_npow2
    assign wr_in_range_c = ({1'b0, bus.wr_addr} < (ADDR_W + 1)'(DEPTH));
    assign rd_in_range_c = ({1'b0, bus.rd_addr} < (ADDR_W + 1)'(DEPTH));
  end

  logic             accept_c;
  logic             user_we_c;
  logic             rd_en_c;
  logic [WIDTH-1:0] wr_word_c;
  logic [WIDTH-1:0] rd_word_c;

  assign accept_c  = !reset && !busy && !bus.clear;
  assign user_we_c = accept_c && bus.store && wr_in_range_c && (|bus.be);
  assign rd_en_c   = accept_c && bus.load;

  // Merged word: enabled bytes from data, the rest from the stored word
  always_comb begin
    wr_word_c = mem_q[bus.wr_addr];
    for (int b = 0; b < BE_W; b++) begin
      if (bus.be[b]) wr_word_c[b*BYTE_W +: BYTE_W] = bus.data[b*BYTE_W +: BYTE_W];
    end
  end

  always_comb begin
    rd_word_c = '0;
    if (rd_in_range_c) begin
      if (user_we_c && (bus.wr_addr == bus.rd_addr)) rd_word_c = wr_word_c;
      else                                           rd_word_c = mem_q[bus.rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we)         mem_q[clr_addr]    <= '0;
    else if (user_we_c) mem_q[bus.wr_addr] <= wr_word_c;
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;

  always_comb begin
    q_d       = q_q;
    q_valid_d = rd_en_c;
    if (rd_en_c) q_d = rd_word_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.busy    = busy;

endmodule
